spi_master_periph: RTL

//  APB-slave SPI master peripheral that sits on the MCU APB bus next to UART/US/DHT.
//  - Consumes APB master transfers (PSEL/PENABLE/PWRITE); shifts 8-bit frames to/from an external SPI device.
//  - Single-byte, MSB-first, modes 0-3, programmable SCLK divider, level IRQ on completion.

---
 rtl/spi_master_periph.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_periph.sv
// APB slave SPI master: single 8-bit MSB-first frames, modes 0-3, programmable SCLK divider.
// Optional feature macro SPI_LOOPBACK_EN adds CR[5]=LOOP (shifter samples mosi internally).
module spi_master_periph #(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_DIV = 8'd4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n,
    output logic              irq
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d, hdiv_q, hdiv_d, shreg_q, shreg_d;
    logic [7:0] tdr_q, tdr_d, rdr_q, rdr_d, clkdiv_q, clkdiv_d;
    logic [3:0] tog_q, tog_d;
    logic       en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d, ie_q, ie_d;
    logic       done_q, done_d, ovr_q, ovr_d, fcpha_q, fcpha_d, samp_q, samp_d;
    logic       sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
    logic       loop_q, rx_bit;

    logic        wr, rd, busy, start, half_end;
    logic [1:0]  idx;
    logic [31:0] rdata;
    logic        unused_bits;

    assign idx      = PADDR[3:2];
    assign PREADY   = PSEL & PENABLE;
    assign wr       = PREADY & PWRITE;
    assign rd       = PREADY & ~PWRITE;
    assign busy     = (state_q != S_IDLE);
    assign start    = wr && (idx == 2'd0) && PWDATA[3] && PWDATA[0] && !busy;
    assign half_end = (cnt_q == hdiv_q);

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;
    assign irq  = done_q & ie_q;

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

`ifdef SPI_LOOPBACK_EN
    logic floop_q;
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            loop_q  <= 1'b0;
            floop_q <= 1'b0;
        end else begin
            if (wr && idx == 2'd0) loop_q <= PWDATA[5];
            if (start)             floop_q <= PWDATA[5];
        end
    end
    assign rx_bit = floop_q ? mosi_q : miso;
`else
    assign loop_q = 1'b0;
    assign rx_bit = miso;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            2'd0:    rdata[15:0] = {clkdiv_q, 2'b00, loop_q, ie_q, 1'b0, cpha_q, cpol_q, en_q};
            2'd1:    rdata[2:0]  = {ovr_q, done_q, busy};
            2'd2:    rdata[7:0]  = tdr_q;
            default: rdata[7:0]  = rdr_q;
        endcase
    end
    assign PRDATA = rd ? rdata : 32'h0;

    always_comb begin
        state_d  = state_q;  cnt_d   = cnt_q;   hdiv_d  = hdiv_q;  shreg_d = shreg_q;
        tdr_d    = tdr_q;    rdr_d   = rdr_q;   clkdiv_d = clkdiv_q; tog_d = tog_q;
        en_d     = en_q;     cpol_d  = cpol_q;  cpha_d  = cpha_q;  ie_d    = ie_q;
        done_d   = done_q;   ovr_d   = ovr_q;   fcpha_d = fcpha_q; samp_d  = samp_q;
        sclk_d   = sclk_q;   mosi_d  = mosi_q;  ss_n_d  = ss_n_q;

        if (wr) begin
            case (idx)
                2'd0: begin
                    en_d     = PWDATA[0];
                    cpol_d   = PWDATA[1];
                    cpha_d   = PWDATA[2];
                    ie_d     = PWDATA[4];
                    clkdiv_d = PWDATA[15:8];
                end
                2'd1: begin
                    if (PWDATA[1]) done_d = 1'b0;
                    if (PWDATA[2]) ovr_d  = 1'b0;
                end
                2'd2:    tdr_d = PWDATA[7:0];
                default: ;
            endcase
        end
        if (rd && idx == 2'd3) done_d = 1'b0;

        // EN dropping mid-frame aborts without touching DONE/RDR
        if (busy && !en_q) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            ss_n_d  = 1'b1;
            sclk_d  = cpol_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sclk_d = cpol_q;
                    ss_n_d = 1'b1;
                    if (start) begin
                        state_d = S_SETUP;
                        cnt_d   = 8'd0;
                        tog_d   = 4'd0;
                        hdiv_d  = PWDATA[15:8];
                        fcpha_d = PWDATA[2];
                        sclk_d  = PWDATA[1];
                        ss_n_d  = 1'b0;
                        shreg_d = tdr_q;
                        if (!PWDATA[2]) mosi_d = tdr_q[7];
                    end
                end
                S_SETUP: begin
                    cnt_d = cnt_q + 8'd1;
                    if (half_end) begin
                        cnt_d   = 8'd0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (half_end) begin
                        cnt_d  = 8'd0;
                        sclk_d = ~sclk_q;
                        tog_d  = tog_q + 4'd1;
                        // even toggles are leading edges
                        if (!tog_q[0]) begin
                            if (!fcpha_q) samp_d = rx_bit;
                            else          mosi_d = shreg_q[7];
                        end else begin
                            shreg_d = {shreg_q[6:0], fcpha_q ? rx_bit : samp_q};
                            if (!fcpha_q && tog_q != 4'd15) mosi_d = shreg_q[6];
                        end
                        if (tog_q == 4'd15) state_d = S_HOLD;
                    end
                end
                default: begin
                    cnt_d = cnt_q + 8'd1;
                    if (half_end) begin
                        cnt_d   = 8'd0;
                        state_d = S_IDLE;
                        ss_n_d  = 1'b1;
                        rdr_d   = shreg_q;
                        done_d  = 1'b1;
                        if (done_q) ovr_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= S_IDLE;  cnt_q   <= 8'd0;  hdiv_q  <= 8'd0;  shreg_q <= 8'd0;
            tdr_q    <= 8'd0;    rdr_q   <= 8'd0;  clkdiv_q <= RESET_DIV; tog_q <= 4'd0;
            en_q     <= 1'b0;    cpol_q  <= 1'b0;  cpha_q  <= 1'b0;  ie_q    <= 1'b0;
            done_q   <= 1'b0;    ovr_q   <= 1'b0;  fcpha_q <= 1'b0;  samp_q  <= 1'b0;
            sclk_q   <= 1'b0;    mosi_q  <= 1'b0;  ss_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d; cnt_q   <= cnt_d; hdiv_q  <= hdiv_d; shreg_q <= shreg_d;
            tdr_q    <= tdr_d;   rdr_q   <= rdr_d; clkdiv_q <= clkdiv_d; tog_q <= tog_d;
            en_q     <= en_d;    cpol_q  <= cpol_d; cpha_q <= cpha_d; ie_q    <= ie_d;
            done_q   <= done_d;  ovr_q   <= ovr_d; fcpha_q <= fcpha_d; samp_q  <= samp_d;
            sclk_q   <= sclk_d;  mosi_q  <= mosi_d; ss_n_q <= ss_n_d;
        end
    end
endmodule
